// File: rtl/sm3_permutation_pipe.sv
// sm3_permutation_pipe
// Elastic valid/ready pipeline that applies the SM3 permutation to one word
// per cycle. Mode 0 computes P0(X) = X ^ rotl(X,9) ^ rotl(X,17) and mode 1
// computes P1(X) = X ^ rotl(X,15) ^ rotl(X,23). The mode is chosen per word.
// The permutation is evaluated combinationally at the input. The result then
// travels through DEPTH register stages together with its mode tag.
// Word bit 0 is the MSB, so ports and internal words use [0:WIDTH-1].

module sm3_permutation_pipe #(
    parameter int WIDTH    = 32,
    parameter int P0_ROT_A = 9,
    parameter int P0_ROT_B = 17,
    parameter int P1_ROT_A = 15,
    parameter int P1_ROT_B = 23,
    parameter int DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [0:WIDTH-1] in_X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_result,
    output logic             out_mode,
    output logic             busy,
    output logic [15:0]      word_count
);

    // Rotation amounts reduced modulo the word width. A reduced amount of 0
    // makes the rotation an identity.
    localparam int ROT0A = P0_ROT_A % WIDTH;
    localparam int ROT0B = P0_ROT_B % WIDTH;
    localparam int ROT1A = P1_ROT_A % WIDTH;
    localparam int ROT1B = P1_ROT_B % WIDTH;

    // Left rotation on an MSB-first word: output bit i takes input bit
    // (i + n) mod WIDTH. With n = 0 this is a plain copy, so no zero-width
    // slice is ever needed.
    function automatic logic [0:WIDTH-1] rotl(input logic [0:WIDTH-1] x,
                                              input int               n);
        logic [0:WIDTH-1] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[(i + n) % WIDTH];
        end
        return r;
    endfunction

    logic [0:WIDTH-1] perm;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] can_load;
    logic [0:WIDTH-1] data [DEPTH];
    logic             tag  [DEPTH];
    logic             full;
    logic             out_fire;

    // Permute the incoming word with the rotation pair that its mode selects.
    always_comb begin
        perm = '0;
        if (in_mode) begin
            perm = in_X ^ rotl(in_X, ROT1A) ^ rotl(in_X, ROT1B);
        end else begin
            perm = in_X ^ rotl(in_X, ROT0A) ^ rotl(in_X, ROT0B);
        end
    end

    // Backward ready chain. Stage k can load when some stage from k to the
    // output is empty, or when the consumer is taking a word (then the whole
    // chain shifts). Stage k advances when it is valid and its successor can
    // load. The chain is built with a running "all full" accumulator so that
    // no vector bit depends on another bit of the same vector.
    always_comb begin
        adv      = '0;
        can_load = '0;
        full     = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k]      = v[k] & (out_ready | ~full);
            full        = full & v[k];
            can_load[k] = out_ready | ~full;
        end
    end

    assign in_ready = can_load[0];

    // Stage registers. Stage 0 captures the permuted word on an input
    // handshake. Each later stage captures its predecessor's word when that
    // predecessor advances. A stage that loads and drains in the same cycle
    // stays valid and holds the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
                tag[k]  <= 1'b0;
            end
        end else begin
            if (can_load[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    data[0] <= perm;
                    tag[0]  <= in_mode;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (can_load[k]) begin
                    v[k] <= adv[k-1];
                    if (adv[k-1]) begin
                        data[k] <= data[k-1];
                        tag[k]  <= tag[k-1];
                    end
                end
            end
        end
    end

    assign out_fire = v[DEPTH-1] & out_ready;

    // Count delivered results. The counter wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (out_fire) begin
            word_count <= word_count + 16'd1;
        end
    end

    assign out_valid  = v[DEPTH-1];
    assign out_result = data[DEPTH-1];
    assign out_mode   = tag[DEPTH-1];
    assign busy       = |v;

endmodule

// File: tb/tb_sm3_permutation_pipe.sv
// tb_sm3_permutation_pipe
// Self-checking bench for sm3_permutation_pipe.
// It combines a table of known vectors, hand-written stall and reset
// sequences, and a randomly handshaked stream. Every output handshake is
// checked against a scoreboard that an independent reference model fills.

module tb_sm3_permutation_pipe;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic        mode;
        logic [31:0] x;
        logic [31:0] result;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic        mode;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [0:WIDTH-1] in_X;
    logic             out_valid;
    logic             out_ready;
    logic [0:WIDTH-1] out_result;
    logic             out_mode;
    logic             busy;
    logic [15:0]      word_count;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          delivered = 0;
    int          first_out = -1;
    int          last_out = -1;
    logic [15:0] model_count = '0;
    logic [31:0] drv_exp = '0;
    exp_t        sb[$];
    exp_t        mon_e;
    bit          stalled = 1'b0;
    logic [31:0] held_result = '0;
    logic        held_mode = 1'b0;
    vec_t        vecs[6];

    sm3_permutation_pipe #(
        .WIDTH(WIDTH), .P0_ROT_A(9), .P0_ROT_B(17),
        .P1_ROT_A(15), .P1_ROT_B(23), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_X(in_X),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_mode(out_mode),
        .busy(busy), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ref_perm(input logic mode, input logic [31:0] x);
        if (mode) return x ^ rotl32(x, 15) ^ rotl32(x, 23);
        return x ^ rotl32(x, 9) ^ rotl32(x, 17);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic mode, input logic [31:0] x, input logic [31:0] e);
        in_valid = 1'b1;
        in_mode  = mode;
        in_X     = x;
        drv_exp  = e;
    endtask

    // Random traffic: the producer holds each offered word until it is taken.
    task automatic send_random(input int n, input int pv, input int pr);
        int          sent = 0;
        int          tries = 0;
        bit          fire;
        logic        m;
        logic [31:0] x;
        while (sent < n && tries < n * 50) begin
            tries++;
            if (!in_valid && $urandom_range(0, 99) < pv) begin
                m = 1'($urandom_range(0, 1));
                x = $urandom;
                apply_stimulus(m, x, ref_perm(m, x));
            end
            out_ready = ($urandom_range(0, 99) < pr);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (sent < n) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL send_random: sent %0d words, expected %0d", sent, n);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || busy) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0 || busy) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL %s drain: %0d words pending, expected 0", name, sb.size());
        end
    endtask

    // Scoreboard monitor. It records each input handshake and checks each
    // output handshake and the stability of a stalled output.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back('{drv_exp, in_mode});
            end
            if (stalled) begin
                check_output("stall hold result", out_result, held_result);
                check_output("stall hold mode", {31'd0, out_mode}, {31'd0, held_mode});
            end
            if (out_valid && out_ready) begin
                check_output("word_count", {16'd0, word_count}, {16'd0, model_count});
                model_count++;
                delivered++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected output: got 0x%08h, expected no word", out_result);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("result", out_result, mon_e.result);
                    check_output("mode", {31'd0, out_mode}, {31'd0, mon_e.mode});
                end
            end
            stalled     = out_valid && !out_ready;
            held_result = out_result;
            held_mode   = out_mode;
        end
    end

    // Watchdog that guarantees the run always terminates.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          accepted;
        int          base;
        bit          stall_done;
        logic        m;
        logic [31:0] x;

        vecs[0] = '{1'b0, 32'h00000001, 32'h00020201};
        vecs[1] = '{1'b1, 32'h00000001, 32'h00808001};
        vecs[2] = '{1'b0, 32'h80000000, 32'h80010100};
        vecs[3] = '{1'b0, 32'h00000000, 32'h00000000};
        vecs[4] = '{1'b1, 32'h80000000, 32'h80404000};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_X      = '0;
        out_ready = 1'b1;
        #2;
        check_output("reset out_valid", {31'd0, out_valid}, 32'd0);
        check_output("reset out_result", out_result, 32'd0);
        check_output("reset busy", {31'd0, busy}, 32'd0);
        check_output("reset in_ready", {31'd0, in_ready}, 32'd1);
        check_output("reset word_count", {16'd0, word_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Known vectors, one at a time, with latency checks
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].mode, vecs[i].x, vecs[i].result);
            @(negedge clk);
            check_output("idle in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int d = 1; d < DEPTH; d++) begin
                check_output("latency early", {31'd0, out_valid}, 32'd0);
                @(posedge clk);
                #1;
            end
            check_output("latency out_valid", {31'd0, out_valid}, 32'd1);
            check_output("table result", out_result, vecs[i].result);
            check_output("table mode", {31'd0, out_mode}, {31'd0, vecs[i].mode});
            @(posedge clk);
            #1;
            check_output("table word_count", {16'd0, word_count}, i + 1);
        end

        // Back-to-back alternating modes
        base      = delivered;
        first_out = -1;
        for (int i = 0; i < 8; i++) begin
            m = i[0];
            x = $urandom;
            apply_stimulus(m, x, ref_perm(m, x));
            @(negedge clk);
            check_output("b2b in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain("b2b");
        check_output("b2b delivered", delivered - base, 32'd8);
        check_output("b2b consecutive", last_out - first_out + 1, 32'd8);
        check_output("b2b word_count", {16'd0, word_count}, 32'd14);

        // Stall: fill the pipe with the consumer blocked, then release it
        base       = delivered;
        out_ready  = 1'b0;
        accepted   = 0;
        stall_done = 1'b0;
        for (int i = 0; i < 8 && !stall_done; i++) begin
            m = 1'($urandom_range(0, 1));
            x = $urandom;
            apply_stimulus(m, x, ref_perm(m, x));
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                stall_done = 1'b1;
            end
        end
        check_output("stall accepted", accepted, DEPTH);
        repeat (4) begin
            @(negedge clk);
            check_output("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_output("unstall in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("stall");
        check_output("stall delivered", delivered - base, DEPTH + 1);

        // Random handshakes with mixed modes
        send_random(10000, 70, 70);
        drain("random");
        check_output("random word_count", {16'd0, word_count}, {16'd0, model_count});

        // Carry the counter past 0xFFFF
        send_random(65540 - delivered, 100, 100);
        drain("wrap");
        check_output("wrap word_count", {16'd0, word_count}, 32'd4);

        // Reset while two words are in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x = $urandom;
            apply_stimulus(1'b0, x, ref_perm(1'b0, x));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_output("inflight busy", {31'd0, busy}, 32'd1);
        check_output("inflight out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async out_valid", {31'd0, out_valid}, 32'd0);
        check_output("async busy", {31'd0, busy}, 32'd0);
        check_output("async word_count", {16'd0, word_count}, 32'd0);
        check_output("async out_result", out_result, 32'd0);
        check_output("async in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        model_count = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check_output("post reset out_valid", {31'd0, out_valid}, 32'd0);
        apply_stimulus(1'b1, 32'h12345678, ref_perm(1'b1, 32'h12345678));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("post reset");
        check_output("post reset word_count", {16'd0, word_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm3_permutation_pipe.md
Name: sm3_permutation_pipe

Overview:
Parametrised, handshaked, pipelined SM3 permutation engine computing either P0(X) = X ^ rotl(X,9) ^ rotl(X,17) or P1(X) = X ^ rotl(X,15) ^ rotl(X,23), selected per word. It sits between the message-expansion and compression datapaths as a shared permutation resource. Both producer and consumer may stall, so it is a fully elastic valid/ready pipeline with configurable depth, width and rotation amounts.

Parameters:
WIDTH, 32, word width in bits (>= 2)
P0_ROT_A, 9, first left-rotation of mode 0
P0_ROT_B, 17, second left-rotation of mode 0
P1_ROT_A, 15, first left-rotation of mode 1
P1_ROT_B, 23, second left-rotation of mode 1
DEPTH, 2, pipeline register stages (1..4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  pipeline accepts input this cycle
in_mode  input  1  0 = P0, 1 = P1
in_X  input  [0:WIDTH-1]  input word, bit 0 = MSB
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_result  output  [0:WIDTH-1]  permuted word
out_mode  output  1  mode tag travelling with the result
busy  output  1  any stage holds a valid word
word_count  output  16  number of results delivered (out_valid & out_ready), wraps 0xFFFF -> 0x0000

Behaviour:
- Rotation: rotl(X,n) = {X[n:WIDTH-1], X[0:n-1]}; n taken mod WIDTH; n mod WIDTH = 0 yields X unchanged (no zero-width slice).
- Permutation is computed combinationally from in_X/in_mode and captured in stage 0 on input handshake (in_valid & in_ready). Stages 1..DEPTH-1 carry result and mode tag unchanged.
- Each stage k has a valid bit v[k]. Stage k may load when !v[k] or stage k is advancing; stage DEPTH-1 advances when out_ready. Ready is computed combinationally back from out_ready: in_ready = !v[0] | (v[0] advancing). No bubbles: sustained 1 word/cycle when out_ready held high.
- Latency: word accepted in cycle t appears with out_valid in cycle t+DEPTH (out_ready high throughout).
- out_valid = v[DEPTH-1]; out_result/out_mode = stage DEPTH-1 registers. While out_valid & !out_ready, out_result and out_mode hold stable; no word dropped, duplicated or reordered.
- in_valid & !in_ready: input ignored; producer must hold. in_X/in_mode are don't-care when in_valid = 0.
- Simultaneous load and drain of the same stage in one cycle: stage takes new word, v[k] stays 1.
- busy = OR of all v[k].
- word_count increments by 1 on each output handshake, wraps modulo 2^16.
- Reset (async assert, sync release at clk): all v[k] = 0, data/tag registers = 0, word_count = 0; hence out_valid = 0, out_result = 0, out_mode = 0, busy = 0, in_ready = 1 immediately during reset. Mid-stream reset discards all in-flight words.
- Mode is per word; mixed P0/P1 streams back-to-back are legal with no turnaround cycle.

Test Plan:
- Reset then DEPTH=2, mode 0, in_X=0x00000001, out_ready=1 -> out_valid 2 cycles later, out_result=0x00020201, out_mode=0, word_count=1.
- Mode 1, in_X=0x00000001 -> out_result=0x00808001; mode 0, in_X=0x80000000 -> 0x80010100; mode 0, in_X=0x00000000 -> 0x00000000.
- Back-to-back 8 words alternating P0/P1 with out_ready=1 -> 8 consecutive out_valid cycles, correct per-word results and mode tags, in_ready never drops, word_count=8.
- Stall: fill pipeline with out_ready=0 -> in_ready drops after DEPTH words accepted, out_result stable; release out_ready -> all words emerge in order, none lost.
- Random in_valid/out_ready toggling, 10 000 words, mixed modes -> scoreboard exact match against reference model; word_count wraps correctly past 0xFFFF (preload via 65 540 words).
- Assert rst_n low with 2 words in flight -> out_valid, busy, word_count go 0 asynchronously; after release, first new word returns correct result with no stale output.
